// File: rtl/depthwise_pe_array.sv
// Depthwise KxK convolution engine: CP channel lanes per beat, 3-stage multiply /
// accumulate / requantise pipeline with valid-ready flow control and a frame FSM.

module depthwise_pe_lane #(
    parameter int DW = 8,
    parameter int KK = 9,
    parameter int BW = 16,
    parameter int AW = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             act_i,
    input  logic [3:0]       shift_i,
    input  logic [DW*KK-1:0] feat_i,
    input  logic [DW*KK-1:0] wgt_i,
    input  logic [BW-1:0]    bias_i,
    output logic [DW-1:0]    res_o
);
    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = -SAT_MAX - (AW+1)'(1);

    logic [KK-1:0][2*DW-1:0] prod_q, prod_d;
    logic [BW-1:0]           bias_q;
    logic                    act1_q, act2_q;
    logic [AW-1:0]           acc_q, acc_d;
    logic [DW-1:0]           res_q, res_d;
    logic [AW:0]             inc;
    logic signed [AW:0]      rnd, shd;

    always_comb begin
        prod_d = '0;
        for (int t = 0; t < KK; t++)
            prod_d[t] = (2*DW)'($signed(feat_i[t*DW +: DW])) * (2*DW)'($signed(wgt_i[t*DW +: DW]));
    end

    always_comb begin
        acc_d = AW'($signed(bias_q));
        for (int t = 0; t < KK; t++)
            acc_d = acc_d + AW'($signed(prod_q[t]));
    end

    // Round half up, arithmetic shift, then clamp into the signed output range.
    always_comb begin
        inc = '0;
        if (shift_i != 4'd0)
            inc = (AW+1)'(1) << (shift_i - 4'd1);
        rnd = $signed({acc_q[AW-1], acc_q}) + $signed(inc);
        shd = rnd >>> shift_i;
        if (shd > SAT_MAX)
            res_d = {1'b0, {(DW-1){1'b1}}};
        else if (shd < SAT_MIN)
            res_d = {1'b1, {(DW-1){1'b0}}};
        else
            res_d = shd[DW-1:0];
        if (!act2_q)
            res_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            bias_q <= '0;
            act1_q <= 1'b0;
            acc_q  <= '0;
            act2_q <= 1'b0;
            res_q  <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
            bias_q <= bias_i;
            act1_q <= act_i;
            acc_q  <= acc_d;
            act2_q <= act1_q;
            res_q  <= res_d;
        end
    end

    assign res_o = res_q;
endmodule

module depthwise_pe_array #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int CP          = 4,
    parameter int BIAS_WIDTH  = 16,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [7:0]                                   cfg_channels,
    input  logic [7:0]                                   cfg_size,
    input  logic [3:0]                                   cfg_shift,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CP-1:0] in_feature,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CP-1:0] in_weight,
    input  logic [BIAS_WIDTH*CP-1:0]                     in_bias,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_WIDTH*CP-1:0]                     out_feature,
    output logic [7:0]                                   out_group,
    output logic                                         out_pixel_last,
    output logic                                         out_frame_done,
    output logic                                         busy
);
    localparam int KK     = KERNEL_SIZE*KERNEL_SIZE;
    localparam int STAGES = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q;
    logic [7:0]           chan_q, size_q, groups_q, g_q, w_q, h_q, base_q;
    logic [3:0]           shift_q;
    logic                 busy_q, done_q;
    logic [STAGES:1]      vld_q, last_q;
    logic [STAGES:1][7:0] grp_q;
    logic [8:0]           groups_w;
    logic                 adv, accept, grp_last, pipe_drains;

    assign adv         = !vld_q[STAGES] || out_ready;
    assign in_ready    = (state_q == RUN) && adv;
    assign accept      = in_valid && in_ready;
    assign grp_last    = (g_q == groups_q - 8'd1);
    assign groups_w    = (9'(cfg_channels) + 9'(CP - 1)) / 9'(CP);
    // True when the pipeline will hold nothing after this edge.
    assign pipe_drains = (vld_q[STAGES-1:1] == '0) && (!vld_q[STAGES] || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chan_q   <= '0;
            size_q   <= '0;
            groups_q <= '0;
            shift_q  <= '0;
            g_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            base_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start && !done_q) begin
                    chan_q   <= cfg_channels;
                    size_q   <= cfg_size;
                    shift_q  <= cfg_shift;
                    groups_q <= groups_w[7:0];
                    g_q      <= '0;
                    w_q      <= '0;
                    h_q      <= '0;
                    base_q   <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= (cfg_channels == 8'd0 || cfg_size == 8'd0) ? DRAIN : RUN;
                end
                RUN: if (accept) begin
                    if (grp_last) begin
                        g_q    <= '0;
                        base_q <= '0;
                        if (w_q == size_q - 8'd1) begin
                            w_q <= '0;
                            if (h_q == size_q - 8'd1) begin
                                h_q     <= '0;
                                state_q <= DRAIN;
                            end else begin
                                h_q <= h_q + 8'd1;
                            end
                        end else begin
                            w_q <= w_q + 8'd1;
                        end
                    end else begin
                        g_q    <= g_q + 8'd1;
                        base_q <= base_q + 8'(CP);
                    end
                end
                DRAIN: if (pipe_drains) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bubbles carry group 0 / last 0 so side-band outputs stay quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            grp_q  <= '0;
        end else if (adv) begin
            vld_q    <= {vld_q[STAGES-1:1], accept};
            last_q   <= {last_q[STAGES-1:1], accept && grp_last};
            grp_q[1] <= accept ? g_q : 8'd0;
            for (int s = 2; s <= STAGES; s++)
                grp_q[s] <= grp_q[s-1];
        end
    end

    for (genvar l = 0; l < CP; l++) begin : g_lane
        logic lane_act;
        assign lane_act = accept && ((16'(base_q) + 16'(l)) < 16'(chan_q));

        depthwise_pe_lane #(
            .DW (DATA_WIDTH),
            .KK (KK),
            .BW (BIAS_WIDTH),
            .AW (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv),
            .act_i   (lane_act),
            .shift_i (shift_q),
            .feat_i  (in_feature[l*DATA_WIDTH*KK +: DATA_WIDTH*KK]),
            .wgt_i   (in_weight[l*DATA_WIDTH*KK +: DATA_WIDTH*KK]),
            .bias_i  (in_bias[l*BIAS_WIDTH +: BIAS_WIDTH]),
            .res_o   (out_feature[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign out_valid      = vld_q[STAGES];
    assign out_group      = grp_q[STAGES];
    assign out_pixel_last = last_q[STAGES];
    assign out_frame_done = done_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_depthwise_pe_array.sv
// Directed bench for depthwise_pe_array: single-pixel vector table plus
// multi-cycle sequences for grouping, backpressure, throughput and reset abort.

module tb_depthwise_pe_array;
    localparam int DW  = 8;
    localparam int KK  = 9;
    localparam int CP  = 4;
    localparam int BW  = 16;
    localparam int FW  = DW*KK*CP;
    localparam int OW  = DW*CP;
    localparam int BWA = BW*CP;

    logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]     cfg_channels = '0, cfg_size = '0;
    logic [3:0]     cfg_shift = '0;
    logic           in_valid = 1'b0, in_ready;
    logic [FW-1:0]  in_feature = '0, in_weight = '0;
    logic [BWA-1:0] in_bias = '0;
    logic           out_valid, out_ready = 1'b1;
    logic [OW-1:0]  out_feature;
    logic [7:0]     out_group;
    logic           out_pixel_last, out_frame_done, busy;

    depthwise_pe_array dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_channels(cfg_channels), .cfg_size(cfg_size), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_feature(in_feature), .in_weight(in_weight), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_feature(out_feature),
        .out_group(out_group), .out_pixel_last(out_pixel_last),
        .out_frame_done(out_frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int f; int w; int b; int sh; int e; } vec_t;
    vec_t vecs [12];

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    logic done_busy = 1'b0, pre_busy = 1'b0, busy_prev = 1'b0;
    logic [OW-1:0] rq_feat [$];
    logic [7:0]    rq_grp  [$];
    logic          rq_last [$];
    int            rq_cyc  [$];
    int            acc_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) begin
            rq_feat.push_back(out_feature);
            rq_grp.push_back(out_group);
            rq_last.push_back(out_pixel_last);
            rq_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (out_frame_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
            pre_busy  = busy_prev;
        end
        busy_prev = busy;
    end

    function automatic logic [FW-1:0] fill8(input int v);
        logic [FW-1:0] r;
        for (int i = 0; i < KK*CP; i++) r[i*DW +: DW] = 8'(v);
        return r;
    endfunction

    function automatic logic [BWA-1:0] fillb(input int v);
        logic [BWA-1:0] r;
        for (int l = 0; l < CP; l++) r[l*BW +: BW] = 16'(v);
        return r;
    endfunction

    function automatic logic [OW-1:0] rep(input int e);
        logic [OW-1:0] r;
        for (int l = 0; l < CP; l++) r[l*DW +: DW] = 8'(e);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        rq_feat.delete(); rq_grp.delete(); rq_last.delete();
        rq_cyc.delete(); acc_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input int c, input int s, input int sh);
        @(posedge clk); #1;
        cfg_channels = 8'(c); cfg_size = 8'(s); cfg_shift = 4'(sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send_beat(input int f, input int w, input int b);
        bit ok;
        ok = 0;
        in_feature = fill8(f); in_weight = fill8(w); in_bias = fillb(b);
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_beat: got no in_ready want accept within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk(nm, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1,    1,    0,    0,  9};
        vecs[1]  = '{127,  127,  0,    7,  127};
        vecs[2]  = '{127, -128,  0,    7, -128};
        vecs[3]  = '{1,    0,    3,    1,  2};
        vecs[4]  = '{-1,   1,    0,    0, -9};
        vecs[5]  = '{2,    3,   -60,   0, -6};
        vecs[6]  = '{10,   10,   100,  2,  127};
        vecs[7]  = '{-3,   1,    0,    1, -13};
        vecs[8]  = '{5,    5,   -225,  0,  0};
        vecs[9]  = '{0,    0,   -5,    2, -1};
        vecs[10] = '{1,    1,    200,  0,  127};
        vecs[11] = '{1,    1,   -200,  0, -128};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, out_valid, out_pixel_last, out_frame_done, busy, out_group, out_feature}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", {in_ready, out_valid, out_pixel_last, out_frame_done, busy, out_group, out_feature}, '0);

        for (int i = 0; i < 12; i++) begin
            clr();
            start_frame(4, 1, vecs[i].sh);
            send_beat(vecs[i].f, vecs[i].w, vecs[i].b);
            in_valid = 1'b0;
            wait_done($sformatf("vec%0d_done", i));
            chk($sformatf("vec%0d_count", i), 64'(rq_feat.size()), 64'd1);
            if (rq_feat.size() > 0) begin
                chk($sformatf("vec%0d_feature", i), 64'(rq_feat[0]), 64'(rep(vecs[i].e)));
                chk($sformatf("vec%0d_grp_last", i), {rq_grp[0], rq_last[0]}, {8'd0, 1'b1});
            end
        end

        // Unit kernel streamed at full rate; a mid-frame start must be ignored.
        clr();
        start_frame(4, 2, 0);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin start = 1'b1; cfg_channels = 8'd1; end
            send_beat(1, 1, 0);
            start = 1'b0; cfg_channels = 8'd4;
        end
        in_valid = 1'b0;
        wait_done("unit_done");
        chk("unit_count", 64'(rq_feat.size()), 64'd4);
        if (rq_feat.size() == 4 && acc_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("unit_res%0d", k), {rq_feat[k], rq_grp[k], rq_last[k]}, {rep(9), 8'd0, 1'b1});
            chk("unit_latency", 64'(rq_cyc[0] - acc_cyc[0]), 64'd3);
            chk("unit_out_b2b", 64'(rq_cyc[3] - rq_cyc[0]), 64'd3);
            chk("unit_in_b2b", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
            chk("unit_done_timing", 64'(done_cyc - rq_cyc[3]), 64'd1);
            chk("unit_busy_fall", {pre_busy, done_busy}, 2'b10);
        end

        // Partial last group: lanes beyond C must read zero.
        clr();
        start_frame(6, 1, 0);
        send_beat(1, 1, 0);
        send_beat(1, 1, 0);
        in_valid = 1'b0;
        wait_done("partial_done");
        chk("partial_count", 64'(rq_feat.size()), 64'd2);
        if (rq_feat.size() == 2) begin
            chk("partial_g0", 64'(rq_feat[0]), 64'h0909_0909);
            chk("partial_g1", 64'(rq_feat[1]), 64'h0000_0909);
            chk("partial_groups", {rq_grp[0], rq_grp[1]}, 16'h0001);
            chk("partial_last", {rq_last[0], rq_last[1]}, 2'b01);
        end

        // Empty frame goes straight to done.
        clr();
        start_frame(0, 2, 0);
        wait_done("empty_done");
        chk("empty_counts", {32'(rq_feat.size()), 32'(acc_cyc.size())}, 64'd0);

        // Backpressure mid-stream.
        clr();
        start_frame(8, 2, 0);
        fork
            begin : prod
                for (int k = 0; k < 8; k++) send_beat(1, 1, k);
                in_valid = 1'b0;
            end
            begin : cons
                int n;
                bit got;
                logic [40:0] held;
                n = 0; got = 0;
                while (!got && n < 100) begin
                    @(negedge clk);
                    n++;
                    if (out_valid) got = 1;
                end
                chk("bp_first_valid", 64'(got), 64'd1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = {out_valid, out_feature, out_group};
                chk("bp_held_valid", 64'(out_valid), 64'd1);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("bp_stable", 64'({out_valid, out_feature, out_group}), 64'(held));
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done("bp_done");
        chk("bp_count", 64'(rq_feat.size()), 64'd8);
        if (rq_feat.size() == 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("bp_res%0d", k), {rq_feat[k], rq_grp[k], rq_last[k]},
                    {rep(9 + k), 8'(k % 2), 1'(k % 2)});

        // Reset in the middle of a frame.
        clr();
        start_frame(4, 2, 0);
        send_beat(1, 1, 0);
        send_beat(1, 1, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {in_ready, out_valid, out_pixel_last, out_frame_done, busy, out_group, out_feature}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", {32'(done_cnt), 32'(busy)}, 64'd0);
        start_frame(4, 1, 0);
        send_beat(2, 3, -60);
        in_valid = 1'b0;
        wait_done("after_abort_done");
        chk("after_abort_count", 64'(rq_feat.size()), 64'd1);
        if (rq_feat.size() > 0)
            chk("after_abort_res", 64'(rq_feat[0]), 64'(rep(-6)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
